// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: op codes, FSM states, ALU evaluation.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_arb_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    // Divide-by-zero has no quotient; all-ones marks it and is passed through untouched.
    localparam logic [7:0] DIV0_RESULT = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // 4-bit operands, 8-bit result. Sub wraps in 8-bit two's complement,
    // mul keeps the full product, div zero-extends the 4-bit quotient.
    function automatic logic [7:0] alu_eval(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [1:0] op);
        logic [7:0] a_ext;
        logic [7:0] b_ext;
        logic [7:0] res;
        a_ext = {4'h0, a};
        b_ext = {4'h0, b};
        res   = 8'h00;
        case (op)
            OP_ADD: res = a_ext + b_ext;
            OP_SUB: res = a_ext - b_ext;
            OP_MUL: res = a_ext * b_ext;
            OP_DIV: begin
                if (b == 4'h0) begin
                    res = DIV0_RESULT;
                end else begin
                    res = {4'h0, a / b};
                end
            end
            default: res = 8'h00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request and response channels between the command sources, the consumer and the arbiter.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both requests and the response channel.
interface alu_arbiter_if;

    logic       r0_valid;
    logic       r0_ready;
    logic [3:0] r0_a;
    logic [3:0] r0_b;
    logic [1:0] r0_op;

    logic       r1_valid;
    logic       r1_ready;
    logic [3:0] r1_a;
    logic [3:0] r1_b;
    logic [1:0] r1_op;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_result;

    logic       busy;

    // Arbiter side: consumes requests, produces the response.
    modport slave (
        input  r0_valid, r0_a, r0_b, r0_op,
        input  r1_valid, r1_a, r1_b, r1_op,
        input  rsp_ready,
        output r0_ready, r1_ready,
        output rsp_valid, rsp_id, rsp_result,
        output busy
    );

    // Requester / consumer side.
    modport master (
        output r0_valid, r0_a, r0_b, r0_op,
        output r1_valid, r1_a, r1_b, r1_op,
        output rsp_ready,
        input  r0_ready, r1_ready,
        input  rsp_valid, rsp_id, rsp_result,
        input  busy
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Shared 4-bit ALU core: add/sub/mul/div with an 8-bit registered result.
// Latency: one cycle from operands to result.
// Backpressure: none; evaluates every cycle, caller holds operands stable.
module alu_arbiter_alu
    import alu_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] op,
    output logic [7:0] result
);

    // Register the evaluated result each cycle; reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= 8'h00;
        end else begin
            result <= alu_eval(a, b, op);
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing one ALU, held response channel.
// Latency: accept at T, EXEC at T+1, response valid at T+2; one op per 3 cycles peak.
// Backpressure: response held until rsp_ready; no request accepted outside IDLE.
module alu_arbiter
    import alu_arb_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    alu_arbiter_if.slave   bus
);

    state_t     state;
    logic       last;        // requester granted most recently; 1 after reset so r0 wins first
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [1:0] op_q;
    logic       id_q;
    logic       rsp_valid_q;
    logic       busy_q;
    logic [7:0] alu_result;
    logic       gnt0;
    logic       gnt1;
    logic       acc0;
    logic       acc1;

    // Round-robin choice: a lone requester wins, on contention the one not served last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (bus.r0_valid && bus.r1_valid) begin
            gnt0 = last;
            gnt1 = ~last;
        end else begin
            gnt0 = bus.r0_valid;
            gnt1 = bus.r1_valid;
        end
    end

    // Readies only open in IDLE and are held off while reset is asserted.
    assign acc0 = (state == IDLE) && !rst && gnt0;
    assign acc1 = (state == IDLE) && !rst && gnt1;

    assign bus.r0_ready = acc0;
    assign bus.r1_ready = acc1;

    // The ALU output register doubles as the response data holder: operands are
    // frozen from the accept until the next accept, so the result cannot move in RESP.
    assign bus.rsp_result = alu_result;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.busy       = busy_q;

    // Sequencer FSM: latch on accept, one ALU cycle, then hold the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last        <= 1'b1;
            a_q         <= 4'h0;
            b_q         <= 4'h0;
            op_q        <= OP_ADD;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (acc0) begin
                        a_q    <= bus.r0_a;
                        b_q    <= bus.r0_b;
                        op_q   <= bus.r0_op;
                        id_q   <= 1'b0;
                        last   <= 1'b0;
                        state  <= EXEC;
                        busy_q <= 1'b1;
                    end else if (acc1) begin
                        a_q    <= bus.r1_a;
                        b_q    <= bus.r1_b;
                        op_q   <= bus.r1_op;
                        id_q   <= 1'b1;
                        last   <= 1'b1;
                        state  <= EXEC;
                        busy_q <= 1'b1;
                    end
                end
                EXEC: begin
                    state       <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    alu_arbiter_alu u_alu (
        .clk    (clk),
        .rst    (rst),
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result)
    );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single op, contention, div-by-zero, back-pressure, reset mid-op, valid drop.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 2ns after it.
// Backpressure: rsp_ready driven per scenario.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_arbiter_if bus ();

    alu_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
    endtask

    task automatic drive(input logic req, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        if (req) begin
            bus.r1_a = a; bus.r1_b = b; bus.r1_op = op; bus.r1_valid = 1'b1;
        end else begin
            bus.r0_a = a; bus.r0_b = b; bus.r0_op = op; bus.r0_valid = 1'b1;
        end
    endtask

    // Full transaction from IDLE with rsp_ready high; checks grant, latency and result.
    task automatic do_op(input logic req, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op, input logic [7:0] exp);
        drive(req, a, b, op);
        #1;
        chk("grant_r0", bus.r0_ready, req ? 1'b0 : 1'b1);
        chk("grant_r1", bus.r1_ready, req ? 1'b1 : 1'b0);
        tick;                                   // accept edge
        idle_inputs;
        #1;
        chk("exec_busy", bus.busy, 1'b1);
        chk("exec_no_rsp", bus.rsp_valid, 1'b0);
        tick;                                   // now RESP
        chk("rsp_valid", bus.rsp_valid, 1'b1);
        chk("rsp_result", bus.rsp_result, exp);
        chk("rsp_id", bus.rsp_id, req);
        tick;                                   // back in IDLE
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_rsp_valid", bus.rsp_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.r0_a = 4'h0; bus.r0_b = 4'h0; bus.r0_op = OP_ADD;
        bus.r1_a = 4'h0; bus.r1_b = 4'h0; bus.r1_op = OP_ADD;
        idle_inputs;
        bus.rsp_ready = 1'b0;

        // Reset: readies low even with a valid presented, outputs at reset values.
        bus.r0_valid = 1'b1;
        tick;
        #1;
        chk("rst_r0_ready", bus.r0_ready, 1'b0);
        chk("rst_r1_ready", bus.r1_ready, 1'b0);
        tick;
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_result", bus.rsp_result, 8'h00);
        chk("rst_rsp_id", bus.rsp_id, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        bus.r0_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick;

        // Single op: 9 + 7 = 0x10 from r0.
        do_op(1'b0, 4'd9, 4'd7, OP_ADD, 8'h10);

        // Contention from a fresh reset: r0 first, then alternate.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        drive(1'b0, 4'd15, 4'd15, OP_MUL);
        drive(1'b1, 4'd3, 4'd5, OP_SUB);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_r0_ready", bus.r0_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
            chk("cont_r1_ready", bus.r1_ready, (i % 2 == 1) ? 1'b1 : 1'b0);
            tick;
            tick;
            chk("cont_result", bus.rsp_result, (i % 2 == 0) ? 8'hE1 : 8'hFE);
            chk("cont_id", bus.rsp_id, (i % 2 == 1) ? 1'b1 : 1'b0);
            chk("cont_resp_r0_ready", bus.r0_ready, 1'b0);
            chk("cont_resp_r1_ready", bus.r1_ready, 1'b0);
            tick;
        end
        idle_inputs;

        // Divide: by zero passes 0xFF through, then 12/5 = 2.
        do_op(1'b1, 4'd12, 4'd0, OP_DIV, 8'hFF);
        do_op(1'b1, 4'd12, 4'd5, OP_DIV, 8'h02);

        // Back-pressure: response held 10 cycles, readies closed despite valids.
        bus.rsp_ready = 1'b0;
        drive(1'b0, 4'd2, 4'd3, OP_ADD);
        #1;
        chk("bp_grant", bus.r0_ready, 1'b1);
        tick;
        idle_inputs;
        tick;
        drive(1'b0, 4'd1, 4'd1, OP_ADD);
        drive(1'b1, 4'd1, 4'd1, OP_ADD);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
            chk("bp_rsp_result", bus.rsp_result, 8'h05);
            chk("bp_rsp_id", bus.rsp_id, 1'b0);
            chk("bp_r0_ready", bus.r0_ready, 1'b0);
            chk("bp_r1_ready", bus.r1_ready, 1'b0);
            tick;
        end
        idle_inputs;
        bus.rsp_ready = 1'b1;
        tick;
        chk("bp_release_busy", bus.busy, 1'b0);
        chk("bp_release_valid", bus.rsp_valid, 1'b0);

        // Reset while in EXEC: op discarded, outputs at reset values, r0 wins next contention.
        drive(1'b1, 4'd2, 4'd3, OP_MUL);
        #1;
        chk("rmid_grant", bus.r1_ready, 1'b1);
        tick;
        idle_inputs;
        chk("rmid_exec_busy", bus.busy, 1'b1);
        rst = 1'b1;
        tick;
        chk("rmid_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rmid_rsp_result", bus.rsp_result, 8'h00);
        chk("rmid_rsp_id", bus.rsp_id, 1'b0);
        chk("rmid_busy", bus.busy, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("rmid_no_rsp", bus.rsp_valid, 1'b0);
        end
        drive(1'b0, 4'd1, 4'd1, OP_ADD);
        drive(1'b1, 4'd4, 4'd4, OP_ADD);
        #1;
        chk("rmid_cont_r0", bus.r0_ready, 1'b1);
        chk("rmid_cont_r1", bus.r1_ready, 1'b0);
        tick;
        idle_inputs;
        tick;
        chk("rmid_next_result", bus.rsp_result, 8'h02);
        chk("rmid_next_id", bus.rsp_id, 1'b0);
        tick;

        // Valid drop: r1 pulses during RESP, never accepted, no response for it.
        bus.rsp_ready = 1'b0;
        drive(1'b0, 4'd5, 4'd1, OP_SUB);
        #1;
        tick;
        idle_inputs;
        tick;
        drive(1'b1, 4'd1, 4'd1, OP_ADD);
        #1;
        chk("vdrop_r1_ready", bus.r1_ready, 1'b0);
        tick;
        idle_inputs;
        chk("vdrop_result", bus.rsp_result, 8'h04);
        chk("vdrop_id", bus.rsp_id, 1'b0);
        bus.rsp_ready = 1'b1;
        tick;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("vdrop_idle_busy", bus.busy, 1'b0);
            chk("vdrop_no_rsp", bus.rsp_valid, 1'b0);
            tick;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared 4-bit ALU. Accepts one operation at a time from either requester via valid/ready, drives it through one ALU evaluation, and returns the 8-bit result with a requester ID on a held response channel. Sits between the front-end command sources and the ALU, so the ALU is never driven by two masters and never loses a result.

## Interface
- No parameters; requester count fixed at 2, operand width 4, result width 8.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- r0_valid / r1_valid  in  1  requester n presents an operation
- r0_ready / r1_ready  out  1  arbiter accepts requester n this cycle
- r0_a, r0_b / r1_a, r1_b  in  4  operands
- r0_op / r1_op  in  2  00 add, 01 sub, 10 mul, 11 div
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that issued the result
- rsp_result  out  8  ALU result
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if one valid is high, grant it; if both are high, grant the one not granted last (round-robin pointer `last`). Only the granted requester's ready is high, combinationally from valid and `last`. Both readies stay low outside IDLE. On a handshake, latch a, b, op, id; update `last`; go to EXEC.
- EXEC: latched operands and op drive the ALU for exactly one cycle. The ALU registers its result at the end of this cycle. Go to RESP.
- RESP: capture the ALU result into rsp_result on entry. Hold rsp_valid, rsp_result and rsp_id stable until rsp_ready is high. On handshake go to IDLE.
- ALU arithmetic, 8-bit result:
  - add: zero-extended sum.
  - sub: 8-bit two's-complement wrap, e.g. 3−5 = 8'hFE.
  - mul: full product, max 15×15 = 8'hE1.
  - div: {4'h0, quotient}.
  - div with b==0: 8'hFF.
- The arbiter does not reinterpret results. An 8'hFF from div is passed through unchanged.
- Requester valid deasserted without a handshake: no effect. Operands are sampled only on the handshake cycle.
- rsp_ready high while rsp_valid is low: ignored.

## Timing
- Reset values: r0_ready=0, r1_ready=0 during the reset cycle, rsp_valid=0, rsp_result=8'h00, rsp_id=0, busy=0, state=IDLE, `last`=1 (r0 wins the first contention).
- Request handshake at cycle T. EXEC at T+1. rsp_valid first high at T+2.
- If rsp_ready is high at T+2, the FSM is in IDLE at T+3 and the next accept can occur at T+3. Peak throughput is one operation per 3 cycles.
- Back-pressure: rsp_valid stays high indefinitely with rsp_ready low. No new request is accepted while it is high.
- rst mid-operation (EXEC or RESP): the in-flight operation is discarded with no response, and all outputs go to their reset values next cycle. The ALU instance shares rst.
- Simultaneous request while in RESP: not accepted. The request waits for IDLE, where round-robin applies.

## Structure
- Shared package `alu_arb_pkg`:
  - op encoding localparams OP_ADD/OP_SUB/OP_MUL/OP_DIV
  - DIV0_RESULT = 8'hFF
  - state enum {IDLE, EXEC, RESP}
- One sub-module: a single instance of the team's ALU core (clk, rst, 4-bit a/b, 2-bit op, registered 8-bit result), fed from the latched operand registers.
- Everything else is flat: FSM, round-robin pointer, operand latch, response register.

## Test plan
- Single op: after reset, r0 add a=4'd9 b=4'd7, rsp_ready=1 -> r0_ready at T, rsp_valid at T+2 with rsp_result=8'h10, rsp_id=0, busy low at T+3.
- Contention: r0 and r1 both valid continuously, r0 mul 15×15, r1 sub 3−5 -> grants alternate r0, r1, r0…. Responses are 8'hE1 (id 0) and 8'hFE (id 1).
- Div by zero: r1 div a=4'd12 b=0 -> rsp_result=8'hFF, id 1. Then div 12/5 -> 8'h02.
- Back-pressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid, rsp_result and rsp_id stable, both readies low. Release -> IDLE the next cycle.
- Reset mid-op: assert rst in EXEC -> no response ever appears for that op, all outputs at reset values. The next r0/r1 contention grants r0 first.
- Valid drop: r1_valid pulses for one cycle while the FSM is in RESP -> not accepted, and no response is produced for it.
